wash_heater_controller: RTL
===========================

# wash_heater_controller

Closed-loop water-heating sequencer that consumes the 6-bit target temperature produced by the temperature selector and drives the heater element. On `start` it snapshots the target and heats the drum until the sensor reading reaches it. It then holds temperature with hysteresis for a fixed soak period and reports completion to the main wash FSM. Heating timeout and over-temperature are latched as a sticky fault.

## Interface
- `HYST`, 2: hysteresis band in °C below target before the heater re-enables during HOLD
- `HEAT_TIMEOUT`, 16'd50000: maximum cycles allowed in HEATING
- `HOLD_CYCLES`, 16'd10000: soak duration in cycles spent in HOLD
- `OVERTEMP`, 7'd90: sensor value (°C) at or above which a fault is forced

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request heating cycle; sampled only in IDLE
- `abort`  in  1  cancel heating/hold, return to IDLE
- `target_temp`  in  6  target °C from temperature selector (10/30/40/60)
- `water_temp`  in  7  current water temperature from sensor, °C, unsigned
- `heater_on`  out  1  heater element enable (registered)
- `heat_ready`  out  1  high while in HOLD (water at temperature)
- `done`  out  1  one-cycle pulse on HOLD completion
- `fault`  out  1  sticky fault indicator
- `state`  out  3  current FSM state for debug/status

## Operation
- States: IDLE=0, HEATING=1, HOLD=2, DONE=3, FAULT=4; other encodings decode as IDLE.
- Reset: state=IDLE. All outputs 0. Target snapshot, timeout counter and hold counter cleared.
- Priority at every edge: reset > over-temperature > abort > normal transitions.
- Over-temperature: `water_temp >= OVERTEMP` in any state other than FAULT goes to FAULT.
- IDLE:
  - `heater_on`=0.
  - `start`=1 latches `tgt_q <= {1'b0,target_temp}`, clears the timeout counter, goes to HEATING.
  - Later changes on `target_temp` are ignored until the next IDLE.
- HEATING:
  - `heater_on`=1 while `water_temp < tgt_q`.
  - `water_temp >= tgt_q`: clear the hold counter, go to HOLD, `heater_on`=0.
  - Otherwise the timeout counter increments. If it equals `HEAT_TIMEOUT-1` at an edge where the water is still below target, go to FAULT.
- HOLD:
  - `heat_ready`=1.
  - Thermostat: `heater_on` sets when `water_temp < tgt_q - HYST` and clears when `water_temp >= tgt_q`; it keeps its value inside the band.
  - Subtraction saturates at 0.
  - The hold counter increments every cycle. At `HOLD_CYCLES-1`, go to DONE.
- DONE: `done`=1 for exactly one cycle, `heater_on`=0, then go to IDLE. `start` is ignored in DONE.
- FAULT:
  - `heater_on`=0, `heat_ready`=0, `fault`=1.
  - FAULT is left only by reset; `start`/`abort` are ignored.
- abort: in HEATING or HOLD, goes to IDLE with `heater_on`=0 and counters cleared. No effect in IDLE, DONE or FAULT.
- Simultaneous `start` and `abort` in IDLE: `start` wins, because `abort` has no effect in IDLE.
- Counters: 16-bit, no wrap is reachable because the state exits at terminal count.

## Timing
- All outputs are registered and change only on the rising `clk` edge.
- `heater_on`, `heat_ready`, `done`, `fault` and `state` are computed from the next state plus `water_temp` sampled at that edge.
- start → HEATING with `heater_on`=1: 1 cycle, i.e. visible after the edge that samples `start`.
- Reaching target → HOLD with `heater_on`=0: 1 cycle.
- HOLD duration: exactly `HOLD_CYCLES` cycles with `heat_ready`=1, then one DONE cycle, then IDLE. Back-to-back `start` is accepted on the first IDLE cycle.
- Over-temperature, abort or timeout → `heater_on`=0: 1 cycle.
- Reset mid-operation: state and outputs return to reset values after the reset edge; `fault` clears.

## Test plan
- Normal cycle with HOLD_CYCLES=8, target=40, water 20 ramping +1/cycle:
  - heater_on=1 from the cycle after start.
  - HOLD is entered the cycle after water=40; heat_ready is high for 8 cycles.
  - A single done pulse is followed by IDLE.
- Hysteresis with HYST=2, target=30, in HOLD:
  - water drops 30→29→28: heater stays 0.
  - water 27: heater_on=1.
  - water 29: heater stays 1.
  - water 30: heater_on=0.
- Timeout with HEAT_TIMEOUT=16, target=60, water fixed 25: FAULT after 16 cycles in HEATING, heater_on=0, fault=1; start is then ignored until reset.
- Over-temperature: in HOLD with target 60, water jumps to 90 → FAULT next cycle with heater_on=0. The same check is repeated from IDLE.
- Target change and abort:
  - target_temp changes 40→10 during HEATING: tgt_q remains 40.
  - abort during HOLD → IDLE next cycle, heat_ready=0, done never asserts.
- Reset mid-HEATING and start+abort together in IDLE:
  - reset mid-HEATING clears all outputs.
  - start=1 and abort=1 in IDLE → HEATING.

Source files
------------

// File: rtl/wash_heater_controller.sv
// Water-heating sequencer: snapshot target on start, heat to target, soak with
// hysteresis thermostat for a fixed period, pulse done; timeout/over-temp latch a fault.
module wash_heater_controller #(
  parameter int          HYST         = 2,
  parameter logic [15:0] HEAT_TIMEOUT = 16'd50000,
  parameter logic [15:0] HOLD_CYCLES  = 16'd10000,
  parameter logic [6:0]  OVERTEMP     = 7'd90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] target_temp,
  input  logic [6:0] water_temp,
  output logic       heater_on,
  output logic       heat_ready,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEATING = 3'd1,
    S_HOLD    = 3'd2,
    S_DONE    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [6:0] HYST_W = 7'(HYST);

  logic [2:0]  state_q;
  state_t      cur, state_d;
  logic [6:0]  tgt_q, tgt_d, lo_thr;
  logic [15:0] tmo_cnt, tmo_d, hold_cnt, hold_d;
  logic        heater_d;

  // Unused encodings fall back to IDLE.
  always_comb begin
    case (state_q)
      3'd1:    cur = S_HEATING;
      3'd2:    cur = S_HOLD;
      3'd3:    cur = S_DONE;
      3'd4:    cur = S_FAULT;
      default: cur = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = cur;
    tgt_d   = tgt_q;
    tmo_d   = tmo_cnt;
    hold_d  = hold_cnt;
    if (cur != S_FAULT && water_temp >= OVERTEMP) begin
      state_d = S_FAULT;
    end else if (abort && (cur == S_HEATING || cur == S_HOLD)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      hold_d  = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start) begin
            tgt_d   = {1'b0, target_temp};
            tmo_d   = '0;
            state_d = S_HEATING;
          end
        end
        S_HEATING: begin
          if (water_temp >= tgt_q) begin
            hold_d  = '0;
            state_d = S_HOLD;
          end else if (tmo_cnt == HEAT_TIMEOUT - 16'd1) begin
            state_d = S_FAULT;
          end else begin
            tmo_d = tmo_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_CYCLES - 16'd1) state_d = S_DONE;
          else                                 hold_d  = hold_cnt + 16'd1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Re-enable threshold, clamped at 0 for low targets.
  assign lo_thr = (tgt_d > HYST_W) ? (tgt_d - HYST_W) : 7'd0;

  always_comb begin
    heater_d = 1'b0;
    case (state_d)
      S_HEATING: heater_d = (water_temp < tgt_d);
      S_HOLD: begin
        if (water_temp >= tgt_d)      heater_d = 1'b0;
        else if (water_temp < lo_thr) heater_d = 1'b1;
        else                          heater_d = heater_on;
      end
      default:   heater_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= 3'd0;
      tgt_q      <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      heater_on  <= 1'b0;
      heat_ready <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      tmo_cnt    <= tmo_d;
      hold_cnt   <= hold_d;
      heater_on  <= heater_d;
      heat_ready <= (state_d == S_HOLD);
      done       <= (state_d == S_DONE);
      fault      <= (state_d == S_FAULT);
    end
  end

  assign state = state_q;

endmodule
